fd_branch_stage: RTL and testbench

Decode-side counterpart of the fetch stage in the five-stage MIPS pipeline. Holds the F/D pipeline register and resolves `beq`/`bne`/`j`/`jal`/`jr` in D, returning `branch`/`DnPC` to fetch. Detects operand hazards on branch/jump comparisons and produces `pause` (freezes PC and F/D) and `D_bubble` (nop into E). Delayed-branch semantics: the instruction after a branch always executes.

---
 rtl/fd_branch_stage_if.sv | 28 ++
 rtl/fd_branch_stage.sv | 102 ++++++++++
 tb/tb_fd_branch_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fd_branch_stage_if.sv
// Decode-side bundle between fetch, the F/D stage and the hazard/forward network.
// master drives fetch/forward inputs; slave is the F/D branch stage itself.
interface fd_branch_stage_if;
    logic [31:0] F_ins;
    logic [31:0] F_PC;
    logic [31:0] D_rs_val;
    logic [31:0] D_rt_val;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic [31:0] D_ins;
    logic [31:0] D_PC;
    logic        branch;
    logic [31:0] DnPC;
    logic        pause;
    logic        D_bubble;

    modport master (
        output F_ins, F_PC, D_rs_val, D_rt_val, E_wa, E_tnew, M_wa, M_tnew,
        input  D_ins, D_PC, branch, DnPC, pause, D_bubble
    );

    modport slave (
        input  F_ins, F_PC, D_rs_val, D_rt_val, E_wa, E_tnew, M_wa, M_tnew,
        output D_ins, D_PC, branch, DnPC, pause, D_bubble
    );
endinterface

// File: rtl/fd_branch_stage.sv
// F/D register plus D-stage branch/jump resolution; 1-cycle F->D, redirect is combinational.
// Backpressure: operand hazard on a compare/jump raises pause (holds PC and F/D) and D_bubble.
module fd_branch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    fd_branch_stage_if.slave  bus
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    logic [31:0] d_ins_q;
    logic [31:0] d_pc_q;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;

    logic        is_beq;
    logic        is_bne;
    logic        is_jump;
    logic        is_jr;
    logic        uses_rs;
    logic        uses_rt;
    logic        rs_hazard;
    logic        rt_hazard;
    logic        stall;
    logic        taken;
    logic [31:0] target;
    logic [31:0] br_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_ins_q <= 32'd0;
            d_pc_q  <= RESET_PC;
        end else if (!stall) begin
            d_ins_q <= bus.F_ins;
            d_pc_q  <= bus.F_PC;
        end
    end

    assign op    = d_ins_q[31:26];
    assign rs    = d_ins_q[25:21];
    assign rt    = d_ins_q[20:16];
    assign funct = d_ins_q[5:0];
    assign imm16 = d_ins_q[15:0];
    assign imm26 = d_ins_q[25:0];

    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_jump = (op == OP_J) || (op == OP_JAL);
    assign is_jr   = (op == OP_SPECIAL) && (funct == FN_JR);

    assign uses_rs = is_beq || is_bne || is_jr;
    assign uses_rt = is_beq || is_bne;

    // Compares consume operands in D (Tuse 0), so any pending producer in E or M blocks.
    assign rs_hazard = uses_rs && (rs != 5'd0) &&
                       (((bus.E_wa == rs) && (bus.E_tnew != 2'd0)) ||
                        ((bus.M_wa == rs) && (bus.M_tnew != 2'd0)));
    assign rt_hazard = uses_rt && (rt != 5'd0) &&
                       (((bus.E_wa == rt) && (bus.E_tnew != 2'd0)) ||
                        ((bus.M_wa == rt) && (bus.M_tnew != 2'd0)));
    assign stall     = rs_hazard || rt_hazard;

    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = bus.F_PC + 32'd4;
        if (is_beq) begin
            taken  = (bus.D_rs_val == bus.D_rt_val);
            target = d_pc_q + 32'd4 + br_offset;
        end else if (is_bne) begin
            taken  = (bus.D_rs_val != bus.D_rt_val);
            target = d_pc_q + 32'd4 + br_offset;
        end else if (is_jump) begin
            taken  = 1'b1;
            target = {d_pc_q[31:28], imm26, 2'b00};
        end else if (is_jr) begin
            taken  = 1'b1;
            target = bus.D_rs_val;
        end
    end

    assign bus.D_ins    = d_ins_q;
    assign bus.D_PC     = d_pc_q;
    assign bus.pause    = stall;
    assign bus.D_bubble = stall;
    assign bus.branch   = taken && !stall;
    assign bus.DnPC     = (taken && !stall) ? target : (bus.F_PC + 32'd4);

endmodule

// File: tb/tb_fd_branch_stage.sv
// Directed plan cases followed by random traffic, checked against a spec-level model.
module tb_fd_branch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    int   vec  = 0;
    int   errs = 0;

    // reference model of the D register
    logic [31:0] m_ins;
    logic [31:0] m_pc;

    fd_branch_stage_if bus ();

    fd_branch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] mk_jr(input int rs);
        return {6'd0, 5'(rs), 15'd0, 6'b001000};
    endfunction

    // Spec rules evaluated with plain integer arithmetic.
    task automatic model(output bit exp_branch, output bit exp_stall,
                         output logic [31:0] exp_npc);
        int unsigned op, fn, rs, rt;
        bit          is_cond, is_jmp, is_jr, taken;
        longint      tgt;
        int          used[$];
        op = m_ins >> 26;
        fn = m_ins & 32'h3F;
        rs = (m_ins >> 21) & 32'h1F;
        rt = (m_ins >> 16) & 32'h1F;
        is_cond = (op == 4) || (op == 5);
        is_jmp  = (op == 2) || (op == 3);
        is_jr   = (op == 0) && (fn == 8);
        taken   = 0;
        tgt     = 0;
        if (is_cond) begin
            tgt   = longint'(m_pc) + 4 + 4 * longint'($signed(m_ins[15:0]));
            taken = (op == 4) ? (bus.D_rs_val == bus.D_rt_val) : (bus.D_rs_val != bus.D_rt_val);
            used.push_back(rs);
            used.push_back(rt);
        end else if (is_jmp) begin
            tgt   = (longint'(m_pc) / 268435456) * 268435456 + longint'(m_ins & 32'h03FF_FFFF) * 4;
            taken = 1;
        end else if (is_jr) begin
            tgt   = bus.D_rs_val;
            taken = 1;
            used.push_back(rs);
        end
        exp_stall = 0;
        foreach (used[i]) begin
            if (used[i] != 0 &&
                ((bus.E_wa == used[i] && bus.E_tnew > 0) || (bus.M_wa == used[i] && bus.M_tnew > 0)))
                exp_stall = 1;
        end
        exp_branch = taken && !exp_stall;
        exp_npc    = exp_branch ? 32'(tgt) : 32'(longint'(bus.F_PC) + 4);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          eb, es;
        logic [31:0] en;
        model(eb, es, en);
        chk("D_ins", bus.D_ins, m_ins);
        chk("D_PC", bus.D_PC, m_pc);
        chk("branch", 32'(bus.branch), 32'(eb));
        chk("DnPC", bus.DnPC, en);
        chk("pause", 32'(bus.pause), 32'(es));
        chk("D_bubble", 32'(bus.D_bubble), 32'(es));
    endtask

    // One clock edge; the model updates from the values present at the edge.
    task automatic tick();
        bit          eb, es;
        logic [31:0] en;
        @(posedge clk);
        model(eb, es, en);
        if (reset) begin
            m_ins = 32'd0;
            m_pc  = RST_PC;
        end else if (!es) begin
            m_ins = bus.F_ins;
            m_pc  = bus.F_PC;
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input int ewa, input int et, input int mwa, input int mt);
        bus.F_ins    = ins;
        bus.F_PC     = pc;
        bus.D_rs_val = rsv;
        bus.D_rt_val = rtv;
        bus.E_wa     = 5'(ewa);
        bus.E_tnew   = 2'(et);
        bus.M_wa     = 5'(mwa);
        bus.M_tnew   = 2'(mt);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        m_ins = 32'hxxxx_xxxx;
        m_pc  = 32'hxxxx_xxxx;
        reset = 1'b1;
        drive(32'd0, RST_PC, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // reset state
        drive(32'd0, RST_PC, 0, 0, 0, 0, 0, 0);
        check_all();
        chk("rst_D_PC", bus.D_PC, 32'h3000);
        chk("rst_DnPC", bus.DnPC, 32'h3004);
        tick();
        chk("first_D_PC", bus.D_PC, 32'h3000);

        // beq taken forward
        drive(mk_i(6'b000100, 1, 2, 16'h0003), 32'h3004, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h3008, 5, 5, 0, 0, 0, 0);
        check_all();
        chk("beq_branch", 32'(bus.branch), 1);
        chk("beq_DnPC", bus.DnPC, 32'h3014);

        // bne with equal operands: not taken
        drive(mk_i(6'b000101, 1, 2, 16'h0003), 32'h3004, 5, 5, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h3008, 5, 5, 0, 0, 0, 0);
        check_all();
        chk("bne_nt_DnPC", bus.DnPC, 32'h300C);

        // backward bne
        drive(mk_i(6'b000101, 1, 2, 16'hFFFE), 32'h3010, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h3014, 1, 2, 0, 0, 0, 0);
        check_all();
        chk("bne_back_DnPC", bus.DnPC, 32'h300C);

        // offset -1 word lands on D_PC
        drive(mk_i(6'b000100, 3, 3, 16'hFFFF), 32'h3010, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h3014, 7, 7, 0, 0, 0, 0);
        chk("beq_m1_DnPC", bus.DnPC, 32'h3010);

        // jal
        drive(mk_j(6'b000011, 26'h0000C04), 32'h3008, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h300C, 0, 0, 0, 0, 0, 0);
        check_all();
        chk("jal_DnPC", bus.DnPC, 32'h3010);

        // jr
        drive(mk_jr(31), 32'h3010, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h3014, 32'h3020, 0, 0, 0, 0, 0);
        check_all();
        chk("jr_branch", 32'(bus.branch), 1);
        chk("jr_DnPC", bus.DnPC, 32'h3020);

        // hazard on rs from E, then release
        drive(mk_i(6'b000100, 8, 9, 16'h0004), 32'h3020, 0, 0, 0, 0, 0, 0);
        tick();
        held = bus.D_ins;
        drive(32'h1234_5678, 32'h3024, 3, 3, 8, 1, 0, 0);
        check_all();
        chk("haz_pause", 32'(bus.pause), 1);
        chk("haz_bubble", 32'(bus.D_bubble), 1);
        chk("haz_branch", 32'(bus.branch), 0);
        tick();
        chk("haz_hold", bus.D_ins, mk_i(6'b000100, 8, 9, 16'h0004));
        drive(32'h1234_5678, 32'h3024, 3, 3, 8, 0, 0, 0);
        check_all();
        chk("rel_branch", 32'(bus.branch), 1);
        chk("rel_DnPC", bus.DnPC, 32'h3034);

        // register 0 never stalls
        drive(mk_i(6'b000100, 0, 0, 16'h0002), 32'h3030, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'd0, 32'h3034, 0, 0, 0, 2, 0, 3);
        check_all();
        chk("r0_pause", 32'(bus.pause), 0);

        // reset during a stall
        drive(mk_i(6'b000101, 4, 5, 16'h0002), 32'h3040, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'hDEAD_BEEF, 32'h3000, 1, 2, 0, 0, 5, 2);
        chk("pre_rst_pause", 32'(bus.pause), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_all();
        chk("rst_stall_ins", bus.D_ins, 32'd0);
        chk("rst_stall_pc", bus.D_PC, 32'h3000);
        chk("rst_stall_pause", 32'(bus.pause), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins, pc, rsv, rtv;
            int          kind, rs, rt;
            rs   = $urandom_range(0, 3);
            rt   = $urandom_range(0, 3);
            kind = $urandom_range(0, 6);
            case (kind)
                0: ins = mk_i(6'b000100, rs, rt, 16'($urandom));
                1: ins = mk_i(6'b000101, rs, rt, 16'($urandom));
                2: ins = mk_j(6'b000010, 26'($urandom));
                3: ins = mk_j(6'b000011, 26'($urandom));
                4: ins = mk_jr(rs);
                default: ins = $urandom;
            endcase
            pc  = $urandom;
            rsv = $urandom_range(0, 3);
            rtv = $urandom_range(0, 1) ? rsv : $urandom;
            if ($urandom_range(0, 3) == 0) rsv = $urandom;
            reset = ($urandom_range(0, 29) == 0);
            drive(ins, {pc[31:2], 2'b00}, rsv, rtv, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            check_all();
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
